// File: rtl/mem_access_pkg.sv
// mem_access_pkg: size codes, exception causes and FSM encoding for the MA stage
package mem_access_pkg;
  localparam logic [2:0] LS_B  = 3'b000;
  localparam logic [2:0] LS_H  = 3'b001;
  localparam logic [2:0] LS_W  = 3'b010;
  localparam logic [2:0] LS_BU = 3'b100;
  localparam logic [2:0] LS_HU = 3'b101;
  localparam logic [3:0] EXC_LD_MIS   = 4'd4;
  localparam logic [3:0] EXC_LD_FAULT = 4'd5;
  localparam logic [3:0] EXC_ST_MIS   = 4'd6;
  localparam logic [3:0] EXC_ST_FAULT = 4'd7;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_RESP = 2'd2} state_t;
endpackage

// File: rtl/mem_access_align.sv
// ldst_align: misalignment detect, byte enables, store lane replication and load extraction
module ldst_align import mem_access_pkg::*; (
  input  logic [2:0]  code,
  input  logic [1:0]  adr,
  input  logic [31:0] st_data,
  input  logic [31:0] rdata,
  output logic        misaligned,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] ld_data
);
  logic is_b, is_h, sx;
  logic [7:0] b;
  logic [15:0] h;
  assign is_b = code[1:0] == LS_B[1:0];
  assign is_h = code[1:0] == LS_H[1:0];
  assign sx = ~code[2];
  assign b = rdata[{adr, 3'b000} +: 8];
  assign h = adr[1] ? rdata[31:16] : rdata[15:0];
  assign misaligned = is_h ? adr[0] : (~is_b & (adr != 2'b00));
  assign be = is_b ? 4'b0001 << adr : is_h ? (adr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign wdata = is_b ? {4{st_data[7:0]}} : is_h ? {2{st_data[15:0]}} : st_data;
  assign ld_data = is_b ? {{24{sx & b[7]}}, b} : is_h ? {{16{sx & h[15]}}, h} : rdata;
endmodule

// File: rtl/mem_access.sv
// mem_access: MA stage driving a req/gnt/rvalid data port with timeout and writeback register
module mem_access import mem_access_pkg::*; #(
  parameter int TIMEOUT_CYC = 255,
  parameter int CNT_W = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_ld_ma,
  input  logic        cmd_st_ma,
  input  logic        wbk_rd_reg_ma,
  input  logic [4:0]  rd_adr_ma,
  input  logic [31:0] rd_data_ma,
  input  logic [31:0] st_data_ma,
  input  logic [2:0]  ldst_code_ma,
  output logic        stall_ma,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [29:0] dmem_adr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        wbk_rd_reg_wb,
  output logic [4:0]  rd_adr_wb,
  output logic [31:0] rd_data_wb,
  output logic        ma_exception,
  output logic [3:0]  ma_excep_code,
  output logic [31:0] ma_excep_adr
);
  state_t state, state_n;
  logic [CNT_W-1:0] cnt;
  logic r_st, r_wbk;
  logic [4:0] r_rd;
  logic [2:0] r_code, a_code;
  logic [1:0] a_adr;
  logic [31:0] r_adr, r_sd, a_sd, ld_data, wdata;
  logic [3:0] be;
  logic idle, mem_op, mis, mis_exc, to, done, abort;
  assign idle = state == S_IDLE;
  assign a_code = idle ? ldst_code_ma : r_code;
  assign a_adr = idle ? rd_data_ma[1:0] : r_adr[1:0];
  assign a_sd = idle ? st_data_ma : r_sd;
  ldst_align u_align (
    .code(a_code),
    .adr(a_adr),
    .st_data(a_sd),
    .rdata(dmem_rdata),
    .misaligned(mis),
    .be(be),
    .wdata(wdata),
    .ld_data(ld_data)
  );
  assign mem_op = cmd_ld_ma | cmd_st_ma;
  assign mis_exc = idle & mem_op & mis;
  assign to = cnt == CNT_W'(TIMEOUT_CYC - 1);
  assign done = (state == S_RESP) & dmem_rvalid;
  assign abort = to & (((state == S_REQ) & ~dmem_gnt) | ((state == S_RESP) & ~dmem_rvalid));
  assign stall_ma = ~idle & ~done & ~abort;
  assign dmem_req = state == S_REQ;
  assign dmem_we = dmem_req & r_st;
  assign dmem_adr = dmem_req ? r_adr[31:2] : '0;
  assign dmem_be = dmem_req ? be : '0;
  assign dmem_wdata = dmem_req ? wdata : '0;
  always_comb begin
    state_n = state;
    state_n = idle ? ((mem_op & ~mis) ? S_REQ : S_IDLE) : (done | abort) ? S_IDLE : (dmem_req & dmem_gnt) ? S_RESP : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt <= '0;
      r_st <= 1'b0;
      r_wbk <= 1'b0;
      r_rd <= '0;
      r_code <= '0;
      r_adr <= '0;
      r_sd <= '0;
      wbk_rd_reg_wb <= 1'b0;
      rd_adr_wb <= '0;
      rd_data_wb <= '0;
      ma_exception <= 1'b0;
      ma_excep_code <= '0;
      ma_excep_adr <= '0;
    end else begin
      state <= state_n;
      cnt <= (idle | (state_n != state)) ? '0 : cnt + CNT_W'(1);
      ma_exception <= mis_exc | abort;
      if (mis_exc) begin
        ma_excep_code <= cmd_st_ma ? EXC_ST_MIS : EXC_LD_MIS;
        ma_excep_adr <= rd_data_ma;
      end else if (abort) begin
        ma_excep_code <= r_st ? EXC_ST_FAULT : EXC_LD_FAULT;
        ma_excep_adr <= r_adr;
      end
      if (idle) begin
        r_st <= cmd_st_ma;
        r_wbk <= wbk_rd_reg_ma;
        r_rd <= rd_adr_ma;
        r_code <= ldst_code_ma;
        r_adr <= rd_data_ma;
        r_sd <= st_data_ma;
      end
      if (idle & ~mem_op) begin
        wbk_rd_reg_wb <= wbk_rd_reg_ma;
        rd_adr_wb <= rd_adr_ma;
        rd_data_wb <= rd_data_ma;
      end else if (done) begin
        wbk_rd_reg_wb <= ~r_st & r_wbk;
        if (~r_st) begin
          rd_adr_wb <= r_rd;
          rd_data_wb <= ld_data;
        end
      end else begin
        wbk_rd_reg_wb <= 1'b0;
      end
    end
  end
endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- Memory-access (MA) stage; sits directly downstream of the execution stage and upstream of register writeback.
- Consumes the EX results (load/store commands, effective address or ALU result, store data, size code) and drives a request/grant/response data-memory port.
- Aligns and sign/zero-extends load data, raises misalignment and bus-timeout exceptions, and registers the writeback triple.
- Stalls the upstream pipeline while a memory transaction is outstanding.

Parameters:
TIMEOUT_CYC, 255, max cycles waiting for dmem_gnt or dmem_rvalid before bus error (1..1023)
CNT_W, 10, width of timeout counter

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cmd_ld_ma  in  1  load in MA
cmd_st_ma  in  1  store in MA
wbk_rd_reg_ma  in  1  writeback enable from EX
rd_adr_ma  in  5  destination register
rd_data_ma  in  32  effective address (ld/st) or ALU/CSR result
st_data_ma  in  32  store data (rs2)
ldst_code_ma  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
stall_ma  out  1  freeze EX/ID/IF; inputs held stable by upstream while high
dmem_req  out  1  request valid
dmem_we  out  1  1=write
dmem_adr  out  30  word address [31:2]
dmem_be  out  4  byte enables
dmem_wdata  out  32  lane-replicated store data
dmem_gnt  in  1  request accepted this cycle
dmem_rvalid  in  1  response valid (read data or write ack)
dmem_rdata  in  32  read word
wbk_rd_reg_wb  out  1  writeback enable
rd_adr_wb  out  5  writeback register
rd_data_wb  out  32  writeback data
ma_exception  out  1  1-cycle pulse: misaligned ld/st or bus timeout
ma_excep_code  out  4  4 ld misalign, 6 st misalign, 5 ld access fault, 7 st access fault
ma_excep_adr  out  32  faulting address

Behaviour:
- Reset: all outputs 0; FSM IDLE; counter 0. Reset mid-transaction abandons it; dmem_req drops next cycle, no writeback.
- FSM states: IDLE, REQ, RESP.
- IDLE:
  - Non-memory op with wbk_rd_reg_ma=1: register rd_adr_ma/rd_data_ma into the wb outputs next cycle (1-cycle latency, no stall).
  - Neither ld nor st, and wbk_rd_reg_ma=0: wbk_rd_reg_wb=0 next cycle.
  - Valid ld/st: go to REQ.
- Misalignment check (IDLE, combinational on inputs): H with adr[0]=1, or W with adr[1:0]!=0.
  - No request issued; ma_exception pulses next cycle with code 4/6 and the address.
  - wbk_rd_reg_wb=0; stays IDLE; no stall.
- REQ:
  - dmem_req=1, stall_ma=1; dmem_adr/be/wdata/we held stable until gnt.
  - gnt=1 -> RESP with counter cleared.
- RESP:
  - stall_ma=1 until the cycle dmem_rvalid=1.
  - In that cycle stall_ma=0 and FSM returns to IDLE.
  - Next cycle: loads present extracted data on rd_data_wb with wbk_rd_reg_wb=wbk_rd_reg_ma. Stores drive wbk_rd_reg_wb=0.
  - Load-to-writeback latency is at least 3 cycles (REQ, RESP, wb register).
  - gnt and rvalid in the same cycle while in REQ: the response is ignored; rvalid is only sampled in RESP.
- Byte enables:
  - B: 0001 shifted left by adr[1:0].
  - H: 0011 shifted left by adr[1] *2.
  - W: 1111.
  - Store data replicated per lane: B {4{d[7:0]}}, H {2{d[15:0]}}.
- Load extract:
  - Byte lane = adr[1:0]; half = adr[1].
  - Sign-extend for codes 000/001; zero-extend for 100/101.
  - Code 010 passes the full word. Codes 011/110/111 are treated as W.
- Timeout:
  - Counter increments each cycle in REQ or RESP and clears on state change.
  - Reaching TIMEOUT_CYC: abort to IDLE, deassert dmem_req, pulse ma_exception (code 5 ld / 7 st), no writeback, stall released the same cycle.
  - A late dmem_rvalid arriving in IDLE is ignored.
- cmd_ld_ma and cmd_st_ma both 1: illegal. Treat as store (store has priority).
- ma_exception, ma_excep_code and ma_excep_adr are valid only in the pulse cycle; code/adr hold their last value otherwise.

Decomposition:
- Shared package:
  - ldst_code constants (LS_B=3'b000, LS_H, LS_W, LS_BU, LS_HU).
  - Exception cause constants (4,5,6,7).
  - FSM state encoding (2 bits).
- One natural sub-module: ldst_align. Purely combinational; contains misalignment detect, byte-enable/lane replication and load extraction. The top keeps only the FSM, counter and registers.

Test Plan:
- ALU op: wbk_rd_reg_ma=1, rd_adr=5, data=0x1234 -> next cycle wbk_rd_reg_wb=1, rd_adr_wb=5, rd_data_wb=0x1234, stall_ma never high.
- LB at adr 0x103, gnt after 2 cycles, rvalid after 1 more, rdata=0x80AABBCC:
  - dmem_be=1000 and dmem_adr=0x40 throughout REQ.
  - rd_data_wb=0xFFFFFF80.
  - stall_ma high from the cycle REQ is entered until rvalid.
- LHU at adr 0x102, rdata=0x9ABC1234 -> rd_data_wb=0x00009ABC.
- SB at adr 0x2, st_data=0x112233EE -> dmem_we=1, be=0100, wdata=0xEEEEEEEE, wbk_rd_reg_wb=0 after ack.
- LW at adr 0x6 -> no dmem_req; ma_exception pulse, code 4, adr 0x6; no writeback. SH at 0x1 -> code 6.
- TIMEOUT_CYC=8, LW with gnt never asserted -> exception code 5 exactly 8 cycles after entering REQ, then IDLE. Also assert rst during RESP -> all outputs 0 next cycle.
